// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: width codes, status codes,
// FSM encoding and the request-check / store-formatting helpers.
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_DONE     = 2'b10,
    ST_ERR_DONE = 2'b11
  } lsu_state_e;

  // Illegal width code outranks misalignment.
  function automatic logic [1:0] check_req(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic illegal;
    logic misalign;
    if (is_store) begin
      illegal = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    case (f3)
      F3_H, F3_HU: misalign = lo[0];
      F3_W:        misalign = (lo != 2'b00);
      default:     misalign = 1'b0;
    endcase
    if (illegal) begin
      return ERR_ILLEGAL;
    end else if (misalign) begin
      return ERR_MISALIGN;
    end else begin
      return ERR_OK;
    end
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Request/response and shared-memory port bundle of the load/store unit.
interface rv32i_lsu_if;
  logic        lsu_start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] load_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  lsu_start, is_store, funct3, addr, store_data,
    output busy, done, err, load_data,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output lsu_start, is_store, funct3, addr, store_data,
    input  busy, done, err, load_data,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/rv32i_lsu_load_align.sv
// Combinational lane select and sign/zero extension of a memory read word.
module lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Extend the selected lane according to the width code.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: checks a request, runs one valid/ready memory access
// with a timeout, and reports completion status with a one-cycle done pulse.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  rv32i_lsu_if.master  bus
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_e  r_state;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_err;
  logic [31:0] r_load_data;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [7:0]  r_cnt;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic [1:0]  w_chk;
  logic [31:0] w_load_ext;

  assign w_chk = check_req(bus.is_store, bus.funct3, bus.addr[1:0]);

  lsu_load_align u_align (
    .i_rdata   (bus.mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_ext)
  );

  // Request FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;
      r_load_data <= 32'h0000_0000;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
      r_cnt       <= 8'd0;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.lsu_start) begin
            r_busy     <= 1'b1;
            r_is_store <= bus.is_store;
            r_funct3   <= bus.funct3;
            r_addr_lo  <= bus.addr[1:0];
            r_cnt      <= 8'd0;
            if (w_chk != ERR_OK) begin
              r_state <= ST_ERR_DONE;
              r_done  <= 1'b1;
              r_err   <= w_chk;
            end else begin
              r_state     <= ST_REQ;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {bus.addr[31:2], 2'b00};
              r_mem_wstrb <= bus.is_store ? store_strb(bus.funct3, bus.addr[1:0]) : 4'b0000;
              r_mem_wdata <= bus.is_store ? store_wdata(bus.funct3, bus.store_data) : 32'h0000_0000;
            end
          end
        end
        ST_REQ: begin
          // A handshake on the final counted cycle still wins over the timeout.
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_err       <= ERR_OK;
            if (!r_is_store) begin
              r_load_data <= w_load_ext;
            end
          end else if (r_cnt == TO_LAST) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_err       <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE, ST_ERR_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= ERR_OK;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b0;
          r_err       <= ERR_OK;
          r_busy      <= 1'b0;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.load_data = r_load_data;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu (MEM_TIMEOUT = 4).
module tb_rv32i_lsu;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rv32i_lsu_if bus ();

  rv32i_lsu #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    bus.lsu_start  = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
  endtask

  // Successful access: ready held low for waitc cycles, then one handshake.
  task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int waitc, input logic [31:0] e_addr, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic [31:0] e_ld);
    start(st, f3, a, sd);
    cyc();
    bus.lsu_start = 1'b0;
    chk({tag, "_valid"}, 32'(bus.mem_valid), 32'd1);
    chk({tag, "_addr"},  bus.mem_addr, e_addr);
    chk({tag, "_strb"},  32'(bus.mem_wstrb), 32'(e_strb));
    if (st) chk({tag, "_wdata"}, bus.mem_wdata, e_wdata);
    chk({tag, "_busy"},  32'(bus.busy), 32'd1);
    chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
    for (int i = 0; i < waitc; i++) begin
      cyc();
      chk({tag, "_wait_valid"}, 32'(bus.mem_valid), 32'd1);
      chk({tag, "_wait_addr"},  bus.mem_addr, e_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0000_0000;
    chk({tag, "_done"},   32'(bus.done), 32'd1);
    chk({tag, "_err"},    32'(bus.err), 32'd0);
    chk({tag, "_vdrop"},  32'(bus.mem_valid), 32'd0);
    chk({tag, "_ld"},     bus.load_data, e_ld);
    cyc();
    chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"},    32'(bus.busy), 32'd0);
  endtask

  // Rejected request: done with err one cycle after start, no memory access.
  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] e_err, input logic [31:0] e_ld);
    start(st, f3, a, 32'h5555_AAAA);
    cyc();
    bus.lsu_start = 1'b0;
    chk({tag, "_done"},  32'(bus.done), 32'd1);
    chk({tag, "_err"},   32'(bus.err), 32'(e_err));
    chk({tag, "_novld"}, 32'(bus.mem_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd1);
    cyc();
    chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
    chk({tag, "_err_lo"},  32'(bus.err), 32'd0);
    chk({tag, "_novld2"},  32'(bus.mem_valid), 32'd0);
    chk({tag, "_idle"},    32'(bus.busy), 32'd0);
    chk({tag, "_ld"},      bus.load_data, e_ld);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.lsu_start  = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    bus.mem_rdata  = 32'h0;
    bus.mem_ready  = 1'b0;
    cyc();
    cyc();
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_strb",  32'(bus.mem_wstrb), 32'd0);
    chk("rst_ld",    bus.load_data, 32'h0);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    cyc();

    // ready raised while idle must not start anything
    bus.mem_ready = 1'b1;
    cyc();
    chk("idle_ready_novld", 32'(bus.mem_valid), 32'd0);
    chk("idle_ready_nodone", 32'(bus.done), 32'd0);
    bus.mem_ready = 1'b0;

    do_access("lb103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0,
              32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    do_access("sh202", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0,
              32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
    do_access("lh002", 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 2,
              32'h0000_0000, 4'b0000, 32'h0, 32'hFFFF_8001);
    do_access("lbu001", 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F200, 1,
              32'h0000_0000, 4'b0000, 32'h0, 32'h0000_00F2);
    do_access("lhu000", 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h1234_9ABC, 0,
              32'h0000_0000, 4'b0000, 32'h0, 32'h0000_9ABC);
    do_access("lw010", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0,
              32'h0000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    do_access("sb003", 1'b1, 3'b000, 32'h0000_0003, 32'h1234_56A5, 32'h0, 0,
              32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    do_access("sw004", 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 3,
              32'h0000_0004, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    do_access("lb100", 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_007F, 0,
              32'h0000_0100, 4'b0000, 32'h0, 32'h0000_007F);

    do_err("lw006",   1'b0, 3'b010, 32'h0000_0006, 2'b01, 32'h0000_007F);
    do_err("st011",   1'b1, 3'b011, 32'h0000_0001, 2'b10, 32'h0000_007F);
    do_err("ld110",   1'b0, 3'b110, 32'h0000_0000, 2'b10, 32'h0000_007F);
    do_err("lh001",   1'b0, 3'b001, 32'h0000_0001, 2'b01, 32'h0000_007F);
    do_err("st100",   1'b1, 3'b100, 32'h0000_0000, 2'b10, 32'h0000_007F);

    // timeout: mem_valid for exactly 4 cycles, then err 11
    start(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    cyc();
    bus.lsu_start = 1'b0;
    chk("to_v1", 32'(bus.mem_valid), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("to_vn", 32'(bus.mem_valid), 32'd1);
      chk("to_nodone", 32'(bus.done), 32'd0);
    end
    cyc();
    chk("to_vdrop", 32'(bus.mem_valid), 32'd0);
    chk("to_done",  32'(bus.done), 32'd1);
    chk("to_err",   32'(bus.err), 32'd3);
    cyc();
    chk("to_idle",  32'(bus.busy), 32'd0);
    chk("to_done_lo", 32'(bus.done), 32'd0);
    chk("to_ld",    bus.load_data, 32'h0000_007F);

    // start pulse while busy is dropped, not queued
    start(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    cyc();
    chk("bz_v1", 32'(bus.mem_valid), 32'd1);
    start(1'b1, 3'b010, 32'h0000_0080, 32'h7777_7777);
    cyc();
    bus.lsu_start = 1'b0;
    chk("bz_addr", bus.mem_addr, 32'h0000_0040);
    chk("bz_strb", 32'(bus.mem_wstrb), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    cyc();
    bus.mem_ready = 1'b0;
    chk("bz_done", 32'(bus.done), 32'd1);
    chk("bz_ld",   bus.load_data, 32'h1122_3344);
    cyc();
    chk("bz_idle", 32'(bus.busy), 32'd0);
    cyc();
    chk("bz_no2nd", 32'(bus.mem_valid), 32'd0);
    chk("bz_no2nd_busy", 32'(bus.busy), 32'd0);

    // reset during an in-flight access
    start(1'b0, 3'b000, 32'h0000_0050, 32'h0);
    cyc();
    bus.lsu_start = 1'b0;
    chk("ra_v1", 32'(bus.mem_valid), 32'd1);
    reset = 1'b1;
    cyc();
    chk("ra_vdrop", 32'(bus.mem_valid), 32'd0);
    chk("ra_nodone", 32'(bus.done), 32'd0);
    chk("ra_busy", 32'(bus.busy), 32'd0);
    chk("ra_ld", bus.load_data, 32'h0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    chk("ra_nodone2", 32'(bus.done), 32'd0);
    chk("ra_novld2", 32'(bus.mem_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
